// File: rtl/key_debounce_if.sv
// Key debounce signal bundle: raw active-low key in, debounced level and
// single-cycle press/release pulses out.
interface key_debounce_if;
  logic i_key_n;
  logic o_level;
  logic o_pressed;
  logic o_released;

  // Driver side (board / testbench).
  modport master (
    output i_key_n,
    input  o_level,
    input  o_pressed,
    input  o_released
  );

  // Debouncer side.
  modport slave (
    input  i_key_n,
    output o_level,
    output o_pressed,
    output o_released
  );
endinterface

// File: rtl/key_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer, 4-state stability FSM with a
// 24-bit stable counter, registered level and press/release pulses.
// Optional auto-repeat of the press pulse is enabled by defining the macro
// KEY_AUTOREPEAT_EN; without it the repeat counter does not exist.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC      = 500000,
  parameter int unsigned REPEAT_DELAY_CYC  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYC = 5000000
) (
  input logic           i_clk,
  input logic           i_rst,
  key_debounce_if.slave bus
);

  localparam logic [23:0] DebLast = 24'(DEBOUNCE_CYC - 1);

  // Elaboration-time range checks on the configuration.
  if (DEBOUNCE_CYC < 2 || DEBOUNCE_CYC > 32'd16777215) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYC must be in 2..2^24-1");
  end
  if (REPEAT_DELAY_CYC < 1 || REPEAT_PERIOD_CYC < 1 ||
      REPEAT_DELAY_CYC > 32'd67108864 || REPEAT_PERIOD_CYC > 32'd67108864) begin : g_bad_repeat
    $error("key_debounce: repeat delay/period must be in 1..2^26");
  end

  typedef enum logic [1:0] {
    S_UP        = 2'd0,
    S_DOWN_WAIT = 2'd1,
    S_DOWN      = 2'd2,
    S_UP_WAIT   = 2'd3
  } state_e;

  logic [1:0]  sync_q;
  logic        key_s;
  state_e      state_q;
  logic [23:0] cnt_q;
  logic        level_q;
  logic        pressed_q;
  logic        released_q;
  logic        press_acc;
  logic        release_acc;

  // Synchronize the asynchronous raw key; reset value is the released level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.i_key_n};
    end
  end

  assign key_s = ~sync_q[1];

  // Debounce window completing on this edge.
  always_comb begin
    press_acc   = (state_q == S_DOWN_WAIT) && key_s  && (cnt_q == DebLast);
    release_acc = (state_q == S_UP_WAIT)   && !key_s && (cnt_q == DebLast);
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [25:0] DlyLast = 26'(REPEAT_DELAY_CYC - 1);
  localparam logic [25:0] PerLast = 26'(REPEAT_PERIOD_CYC - 1);

  logic [25:0] rep_q;
  logic        rep_armed_q; // first repeat already issued, use the period
`endif

  // Stability FSM with registered level and pulse outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_UP;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      pressed_q   <= 1'b0;
      released_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
`endif
    end else begin
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      unique case (state_q)
        S_UP: begin
          if (key_s) begin
            state_q <= S_DOWN_WAIT;
            cnt_q   <= '0;
          end
        end
        S_DOWN_WAIT: begin
          if (!key_s) begin
            state_q <= S_UP;
            cnt_q   <= '0;
          end else if (press_acc) begin
            state_q   <= S_DOWN;
            cnt_q     <= '0;
            level_q   <= 1'b1;
            pressed_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        S_DOWN: begin
          if (!key_s) begin
            state_q <= S_UP_WAIT;
            cnt_q   <= '0;
          end
        end
        S_UP_WAIT: begin
          if (key_s) begin
            state_q <= S_DOWN;
            cnt_q   <= '0;
          end else if (release_acc) begin
            state_q    <= S_UP;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            released_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        default: begin
          state_q <= S_UP;
          cnt_q   <= '0;
        end
      endcase

`ifdef KEY_AUTOREPEAT_EN
      // Repeat timer runs only while pressed; a release edge wins over a repeat.
      if (press_acc || release_acc ||
          !(state_q == S_DOWN || state_q == S_UP_WAIT)) begin
        rep_q       <= '0;
        rep_armed_q <= 1'b0;
      end else if (rep_q == (rep_armed_q ? PerLast : DlyLast)) begin
        pressed_q   <= 1'b1;
        rep_q       <= '0;
        rep_armed_q <= 1'b1;
      end else begin
        rep_q <= rep_q + 26'd1;
      end
`endif
    end
  end

  assign bus.o_level    = level_q;
  assign bus.o_pressed  = pressed_q;
  assign bus.o_released = released_q;

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce: directed scenarios plus random bouncing,
// checked every cycle against a run-length reference model.
module tb_key_debounce;

  localparam int unsigned DEB = 4;
  localparam int unsigned DLY = 10;
  localparam int unsigned PER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_debounce_if bus ();

  key_debounce #(
    .DEBOUNCE_CYC      (DEB),
    .REPEAT_DELAY_CYC  (DLY),
    .REPEAT_PERIOD_CYC (PER)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: two-edge sample delay, then a level flips once the
  // last DEB+1 delayed samples all disagree with the current level.
  logic m_d1, m_d2;
  logic m_level, m_pr, m_rel;
  bit   win[$];
  int   m_press_edge;

  int first_press, first_rel, n_press;

  function automatic void check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endfunction

  function automatic void check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endfunction

  function automatic void model_edge(input logic key, input logic r);
    bit seen;
    bit all_diff;
    int el;
    if (r) begin
      m_d1 = 1'b1;
      m_d2 = 1'b1;
      m_level = 1'b0;
      m_pr = 1'b0;
      m_rel = 1'b0;
      win.delete();
      for (int i = 0; i < int'(DEB) + 1; i++) win.push_back(1'b0);
    end else begin
      seen = ~m_d2;
      m_d2 = m_d1;
      m_d1 = key;
      win.push_back(seen);
      if (win.size() > int'(DEB) + 1) void'(win.pop_front());
      m_pr = 1'b0;
      m_rel = 1'b0;
      all_diff = 1'b1;
      foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        if (m_level) begin
          m_pr = 1'b1;
          m_press_edge = cyc;
        end else begin
          m_rel = 1'b1;
        end
      end
`ifdef KEY_AUTOREPEAT_EN
      else if (m_level) begin
        el = cyc - m_press_edge;
        if (el >= int'(DLY) && ((el - int'(DLY)) % int'(PER)) == 0) m_pr = 1'b1;
      end
`endif
    end
  endfunction

  task automatic step(input logic key, input logic r);
    bus.i_key_n = key;
    rst = r;
    @(posedge clk);
    model_edge(key, r);
    #1;
    check("level", bus.o_level, m_level);
    check("pressed", bus.o_pressed, m_pr);
    check("released", bus.o_released, m_rel);
    check("excl", bus.o_pressed & bus.o_released, 1'b0);
    if (bus.o_pressed) begin
      n_press++;
      if (first_press < 0) first_press = cyc;
    end
    if (bus.o_released && first_rel < 0) first_rel = cyc;
    cyc++;
  endtask

  task automatic hold(input logic key, input int n);
    for (int i = 0; i < n; i++) step(key, 1'b0);
  endtask

  initial begin
    int   e0;
    logic k;
    int   len;
    bit   r;

    bus.i_key_n = 1'b1;
    m_press_edge = 0;
    first_press = -1;
    first_rel = -1;
    n_press = 0;

    // Reset then idle with key released.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    hold(1'b1, 50);
    check_int("idle_no_press", n_press, 0);

    // Clean press held 20 cycles.
    first_press = -1;
    e0 = cyc;
    hold(1'b0, 20);
    check_int("press_latency", first_press, e0 + 6);

    // Clean release.
    first_rel = -1;
    e0 = cyc;
    hold(1'b1, 12);
    check_int("release_latency", first_rel, e0 + 6);

    // Short glitch rejected, then bouncing press.
    n_press = 0;
    hold(1'b0, 3);
    hold(1'b1, 10);
    check_int("glitch_no_press", n_press, 0);
    first_press = -1;
    hold(1'b0, 2);
    hold(1'b1, 1);
    e0 = cyc;
    hold(1'b0, 10);
    check_int("bounce_press_latency", first_press, e0 + 6);
    hold(1'b1, 12);

    // Reset in the middle of a press; key still held afterwards.
    first_press = -1;
    hold(1'b0, 4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check_int("reset_discards_press", first_press, -1);
    e0 = cyc;
    hold(1'b0, 15);
    check_int("press_after_reset", first_press, e0 + 6);
    hold(1'b1, 12);

    // Long hold (exercises auto-repeat when enabled), then release.
    first_press = -1;
    e0 = cyc;
    hold(1'b0, 36);
    check_int("long_hold_first_press", first_press, e0 + 6);
    hold(1'b1, 12);

    // Random segments with bounce and occasional reset.
    for (int s = 0; s < 120; s++) begin
      k = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      r = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < len; i++) step(k, r && (i < 2));
    end
    hold(1'b1, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 500000, meaning consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter REPEAT_DELAY_CYC, default 25000000, meaning cycles from press pulse to first repeat pulse; used only with KEY_AUTOREPEAT_EN.
REQ-003 SHALL have parameter REPEAT_PERIOD_CYC, default 5000000, meaning cycles between subsequent repeat pulses; used only with KEY_AUTOREPEAT_EN.
REQ-004 SHALL have port i_clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_key_n  input  1  raw pushbutton, active-low, asynchronous to i_clk, bouncing.
REQ-007 SHALL have port o_level  output  1  debounced key level, 1 = pressed.
REQ-008 SHALL have port o_pressed  output  1  single-cycle press pulse; drives i_start of the random-number stage.
REQ-009 SHALL have port o_released  output  1  single-cycle release pulse.

Function
REQ-010 SHALL pass i_key_n through a 2-flop synchronizer, inverted to key_s (1 = pressed); no other logic samples i_key_n.
REQ-011 SHALL implement FSM states S_UP, S_DOWN_WAIT, S_DOWN, S_UP_WAIT, encoded in 2 bits.
REQ-012 S_UP: key_s=1 -> S_DOWN_WAIT with stable counter cleared to 0; otherwise stay.
REQ-013 S_DOWN_WAIT: key_s=0 -> S_UP, counter cleared (bounce rejected); key_s=1 with counter=DEBOUNCE_CYC-1 -> S_DOWN; else counter+1.
REQ-014 S_DOWN: key_s=0 -> S_UP_WAIT with counter cleared; otherwise stay.
REQ-015 S_UP_WAIT: key_s=1 -> S_DOWN, counter cleared; key_s=0 with counter=DEBOUNCE_CYC-1 -> S_UP; else counter+1.
REQ-016 o_level SHALL be registered, 1 exactly in states S_DOWN and S_UP_WAIT.
REQ-017 o_pressed SHALL be registered, high for exactly one cycle, in the first cycle o_level reads 1 after a S_DOWN_WAIT->S_DOWN transition.
REQ-018 o_released SHALL be registered, high for exactly one cycle, in the first cycle o_level reads 0 after a S_UP_WAIT->S_UP transition.
REQ-019 Latency: a clean i_key_n change seen at edge 0 SHALL appear on o_level and the pulse output after exactly 2+DEBOUNCE_CYC edges.
REQ-020 Any key_s excursion shorter than DEBOUNCE_CYC cycles SHALL produce no change on any output.
REQ-021 o_pressed and o_released SHALL never be high in the same cycle.
REQ-022 Stable counter width SHALL be 24 bits; counter SHALL never exceed DEBOUNCE_CYC-1 and never wrap.

Reset
REQ-023 While i_rst=1 at a rising edge: synchronizer flops set to released, FSM to S_UP, all counters 0, o_level=0, o_pressed=0, o_released=0.
REQ-024 Reset asserted mid-debounce or mid-press SHALL discard the pending event with no pulse emitted; if the key is still held after reset release, a fresh press SHALL be detected with full REQ-019 latency.

Configuration
REQ-025 With macro KEY_AUTOREPEAT_EN defined: while in S_DOWN/S_UP_WAIT, o_pressed SHALL pulse again REPEAT_DELAY_CYC cycles after the original press pulse, then every REPEAT_PERIOD_CYC cycles, using a 26-bit repeat counter cleared on every press pulse and on leaving the pressed states.
REQ-026 Without KEY_AUTOREPEAT_EN: exactly one o_pressed pulse per accepted press; repeat counter and parameters REQ-002/003 have no hardware.

Verification (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_PERIOD_CYC=3)
REQ-027 Reset 3 cycles, i_key_n=1 -> all outputs 0 for 50 cycles.
REQ-028 i_key_n falls at edge 0, held 20 cycles -> o_pressed=1 only at edge 6, o_level=1 from edge 6; without KEY_AUTOREPEAT_EN no further pulse.
REQ-029 i_key_n low 3 cycles then high -> no output change; then low 2, high 1, low 10 -> single o_pressed 6 edges after final fall.
REQ-030 Held key released at edge 0 -> o_released=1 only at edge 6, o_level=0 from edge 6.
REQ-031 i_rst=1 at edge 4 of a press -> no o_pressed; key still low after reset deasserts -> o_pressed 6 edges after first non-reset edge.
REQ-032 With KEY_AUTOREPEAT_EN, key held 30 cycles after press pulse at edge P -> o_pressed at P, P+10, P+13, P+16, ..., stops on release.
